onchip_mem_dma_master: RTL
==========================

# onchip_mem_dma_master

Avalon-MM initiator that drives the single-port on-chip RAM slave (32-bit words, 16-bit word address, 49152 words, fixed 2-cycle read latency, no waitrequest). It executes word-granular COPY and FILL commands received over a valid/ready command port, buffering reads in 4-word chunks because the RAM cannot read and write in the same cycle. It sits beside the Nios CPU as a second master on the RAM's second slave port, used for block moves and pattern initialisation in the arithmetic demo.

## Interface
- ADDR_W, 16, word-address width
- DATA_W, 32, data width; byteenable is DATA_W/8
- MEM_WORDS, 49152, highest legal end address (exclusive)
- CHUNK, 4, words buffered per read/write phase (power of two, 2..16)
- RD_LAT, 2, slave read latency in cycles
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = COPY, 1 = FILL
- cmd_src  in  ADDR_W  COPY source word address
- cmd_dst  in  ADDR_W  destination word address
- cmd_len  in  ADDR_W  length in words; 0 = no-op
- cmd_fill  in  DATA_W  FILL pattern
- busy  out  1  high from accept until done pulse inclusive
- done  out  1  one-cycle completion pulse
- err  out  1  coincident with done when command was rejected
- checksum  out  DATA_W  sum mod 2^32 of words written by last command
- avm_address  out  ADDR_W, avm_chipselect  out  1, avm_write  out  1, avm_byteenable  out  DATA_W/8 (constant all-ones), avm_writedata  out  DATA_W, avm_readdata  in  DATA_W, avm_clken  out  1 (0 in reset, else 1)

## Operation
- Reset values: cmd_ready 0 during reset, then 1; busy, done, err, chipselect, write 0; address, writedata, checksum 0.
- Accept on cmd_valid & cmd_ready; latch all cmd_* fields; clear checksum.
- States: IDLE, CHECK, RD_ISSUE, RD_DRAIN, WR, FILL, DONE.
- CHECK (1 cycle): len = 0 -> DONE; src+len > MEM_WORDS (COPY) or dst+len > MEM_WORDS -> DONE with err; else COPY -> RD_ISSUE, FILL -> FILL. Sums computed at ADDR_W+1 bits, no wrap.
- RD_ISSUE: n = min(CHUNK, remaining); one read per cycle at src, src+1, ...; chipselect=1, write=0.
- Capture: data for a read issued in cycle t sampled from avm_readdata at end of cycle t+RD_LAT into buffer slot in issue order.
- RD_DRAIN: no access; exit when all n words captured.
- WR: n writes, one per cycle, dst ascending, chipselect=1, write=1; src, dst += n, remaining -= n; remaining 0 -> DONE else RD_ISSUE.
- FILL: len consecutive writes of cmd_fill from dst, one per cycle, then DONE.
- DONE: done=1 (err if rejected) one cycle, busy=1, -> IDLE.
- Overlap: behaviour is exactly ascending chunk-wise copy; overlapping regions with 0 < dst−src < CHUNK are not a supported use.
- reset_n low mid-command: abort immediately, outputs to reset values; memory contents partially written, undefined.

## Timing
- Accept cycle 0, CHECK cycle 1, first access cycle 2.
- Full COPY chunk: CHUNK + RD_LAT + CHUNK cycles (10 at defaults); COPY of L words: 2 + ⌈L/CHUNK⌉·(RD_LAT) + 2L cycles to done, done in the cycle after last write.
- FILL of L words: writes cycles 2..L+1, done cycle L+2.
- Rejected/no-op: done (err) cycle 2, no bus activity.
- cmd_ready returns the cycle after done.

## Configuration
- ONCHIP_DMA_CHECKSUM_EN defined: checksum accumulates every written word (COPY: read data; FILL: cmd_fill per write).
- Undefined: checksum tied to 0, no accumulator logic.

## Structure
- Package onchip_dma_pkg: state enum, op codes (OP_COPY, OP_FILL), default constants (ADDR_W, DATA_W, MEM_WORDS, CHUNK, RD_LAT).
- Sub-module onchip_dma_chunk_buf: CHUNK-deep register buffer with write pointer driven by an RD_LAT-stage read-valid shift register and read pointer driven by WR state.

## Test plan
- FILL dst=0x0100 len=5 pattern 0xA5A5A5A5 -> words 0x0100..0x0104 = pattern, 0x0105 untouched, done cycle 7, checksum 0x3C3C3C39 (macro on).
- COPY src=0x0000 len=4 dst=0x1000, src = 1,2,3,4 -> dst = 1,2,3,4, done cycle 12, checksum 10.
- COPY len=9 (chunks 4,4,1) src 0x2000 -> dst 0x3000 -> all 9 words correct, reads never overlap writes on the bus.
- cmd_len=0 -> done cycle 2, err 0, chipselect never asserted; dst=0xBFFF len=2 -> done+err cycle 2, no access.
- cmd_valid held through busy -> second command accepted only the cycle after done.
- reset_n low during WR of COPY len=8 -> all outputs reset values same cycle, cmd_ready 1 after release, next FILL executes correctly.

Source files
------------

// File: rtl/onchip_dma_pkg.sv
// Shared types and default constants for the on-chip RAM DMA master.
package onchip_dma_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 49152;
    localparam int CHUNK     = 4;
    localparam int RD_LAT    = 2;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RD_ISSUE,
        ST_RD_DRAIN,
        ST_WR,
        ST_FILL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/onchip_dma_chunk_buf.sv
// CHUNK-deep read buffer: slots fill in issue order as read data returns RD_LAT cycles later.
module onchip_dma_chunk_buf #(
    parameter int DATA_W = onchip_dma_pkg::DATA_W,
    parameter int CHUNK  = onchip_dma_pkg::CHUNK,
    parameter int RD_LAT = onchip_dma_pkg::RD_LAT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       rd_issue,
    input  logic [DATA_W-1:0]          din,
    input  logic                       rd_en,
    output logic                       cap_en,
    output logic [$clog2(CHUNK)-1:0]   wr_ptr,
    output logic [DATA_W-1:0]          rdata
);
    localparam int IDX_W = $clog2(CHUNK);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [CHUNK];

    assign cap_en = vld_q[RD_LAT-1];
    assign wr_ptr = wr_ptr_q;
    // A single-word chunk reads its slot in the same cycle it is captured.
    assign rdata  = (cap_en && (wr_ptr_q == rd_ptr_q)) ? din : mem_q[rd_ptr_q];

    always_comb begin
        vld_d    = RD_LAT'({vld_q, rd_issue});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (cap_en) wr_ptr_d = wr_ptr_q + IDX_W'(1);
            if (rd_en)  rd_ptr_d = rd_ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/onchip_mem_dma_master.sv
// Avalon-MM DMA master for COPY/FILL on the single-port on-chip RAM.
// Define ONCHIP_DMA_CHECKSUM_EN to accumulate a checksum of every written word.
module onchip_mem_dma_master #(
    parameter int ADDR_W    = onchip_dma_pkg::ADDR_W,
    parameter int DATA_W    = onchip_dma_pkg::DATA_W,
    parameter int MEM_WORDS = onchip_dma_pkg::MEM_WORDS,
    parameter int CHUNK     = onchip_dma_pkg::CHUNK,
    parameter int RD_LAT    = onchip_dma_pkg::RD_LAT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_W-1:0]     cmd_src,
    input  logic [ADDR_W-1:0]     cmd_dst,
    input  logic [ADDR_W-1:0]     cmd_len,
    input  logic [DATA_W-1:0]     cmd_fill,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     checksum,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic [DATA_W-1:0]     avm_writedata,
    input  logic [DATA_W-1:0]     avm_readdata,
    output logic                  avm_clken
);
    import onchip_dma_pkg::*;

    localparam int IDX_W = $clog2(CHUNK);
    localparam logic [IDX_W:0] ONE_N = (IDX_W+1)'(1);

    state_e state_q, state_d;
    logic op_q, op_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, rem_q, rem_d, addr_q, addr_d;
    logic [DATA_W-1:0] fill_q, fill_d, wdata_q, wdata_d;
    logic [IDX_W:0] n_q, n_d, cnt_q, cnt_d, n_m1;
    logic ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic cs_q, cs_d, we_q, we_d, clken_q;
    logic buf_clr, buf_rd_en, cap_en;
    logic [IDX_W-1:0] wr_ptr;
    logic [DATA_W-1:0] buf_rdata;
    logic [ADDR_W:0] src_end, dst_end;

    function automatic logic [IDX_W:0] chunk_n(input logic [ADDR_W-1:0] r);
        return (r >= ADDR_W'(CHUNK)) ? (IDX_W+1)'(CHUNK) : r[IDX_W:0];
    endfunction

    onchip_dma_chunk_buf #(.DATA_W(DATA_W), .CHUNK(CHUNK), .RD_LAT(RD_LAT)) u_buf (
        .clk(clk), .rst_n(reset_n), .clr(buf_clr), .rd_issue(cs_q & ~we_q),
        .din(avm_readdata), .rd_en(buf_rd_en), .cap_en(cap_en), .wr_ptr(wr_ptr),
        .rdata(buf_rdata)
    );

    assign src_end = {1'b0, src_q} + {1'b0, rem_q};
    assign dst_end = {1'b0, dst_q} + {1'b0, rem_q};
    assign n_m1    = n_q - ONE_N;

    always_comb begin
        state_d = state_q;  op_d = op_q;  src_d = src_q;  dst_d = dst_q;
        rem_d = rem_q;  fill_d = fill_q;  addr_d = addr_q;  wdata_d = wdata_q;
        n_d = n_q;  cnt_d = cnt_q;  cs_d = cs_q;  we_d = we_q;
        err_d = 1'b0;  buf_clr = 1'b0;  buf_rd_en = 1'b0;
        case (state_q)
            ST_IDLE: if (cmd_valid && ready_q) begin
                op_d = cmd_op;  src_d = cmd_src;  dst_d = cmd_dst;
                rem_d = cmd_len;  fill_d = cmd_fill;  state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if ((op_q == OP_COPY && src_end > (ADDR_W+1)'(MEM_WORDS)) ||
                             dst_end > (ADDR_W+1)'(MEM_WORDS)) begin
                    state_d = ST_DONE;  err_d = 1'b1;
                end else if (op_q == OP_COPY) begin
                    state_d = ST_RD_ISSUE;  cs_d = 1'b1;  we_d = 1'b0;  addr_d = src_q;
                    n_d = chunk_n(rem_q);  cnt_d = ONE_N;  buf_clr = 1'b1;
                end else begin
                    state_d = ST_FILL;  cs_d = 1'b1;  we_d = 1'b1;  addr_d = dst_q;
                    wdata_d = fill_q;  rem_d = rem_q - ADDR_W'(1);
                end
            end
            ST_RD_ISSUE: begin
                if (cnt_q < n_q) begin
                    addr_d = addr_q + ADDR_W'(1);  cnt_d = cnt_q + ONE_N;
                end else begin
                    state_d = ST_RD_DRAIN;  cs_d = 1'b0;
                end
            end
            // Leave drain on the edge that captures the chunk's final word.
            ST_RD_DRAIN: if (cap_en && (wr_ptr == n_m1[IDX_W-1:0])) begin
                state_d = ST_WR;  cs_d = 1'b1;  we_d = 1'b1;  addr_d = dst_q;
                wdata_d = buf_rdata;  buf_rd_en = 1'b1;  cnt_d = ONE_N;
            end
            ST_WR: begin
                if (cnt_q < n_q) begin
                    addr_d = addr_q + ADDR_W'(1);  wdata_d = buf_rdata;
                    buf_rd_en = 1'b1;  cnt_d = cnt_q + ONE_N;
                end else begin
                    src_d = src_q + ADDR_W'(n_q);
                    dst_d = dst_q + ADDR_W'(n_q);
                    rem_d = rem_q - ADDR_W'(n_q);
                    if (rem_d == '0) begin
                        state_d = ST_DONE;  cs_d = 1'b0;  we_d = 1'b0;
                    end else begin
                        state_d = ST_RD_ISSUE;  we_d = 1'b0;  addr_d = src_d;
                        n_d = chunk_n(rem_d);  cnt_d = ONE_N;  buf_clr = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (rem_q != '0) begin
                    addr_d = addr_q + ADDR_W'(1);  rem_d = rem_q - ADDR_W'(1);
                end else begin
                    state_d = ST_DONE;  cs_d = 1'b0;  we_d = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;  ready_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
            err_q <= 1'b0;  cs_q <= 1'b0;  we_q <= 1'b0;  addr_q <= '0;  wdata_q <= '0;
            n_q <= '0;  cnt_q <= '0;  clken_q <= 1'b0;
        end else begin
            state_q <= state_d;  ready_q <= ready_d;  busy_q <= busy_d;  done_q <= done_d;
            err_q <= err_d;  cs_q <= cs_d;  we_q <= we_d;  addr_q <= addr_d;  wdata_q <= wdata_d;
            n_q <= n_d;  cnt_q <= cnt_d;  clken_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        op_q <= op_d;  src_q <= src_d;  dst_q <= dst_d;  rem_q <= rem_d;  fill_q <= fill_d;
    end

`ifdef ONCHIP_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (state_q == ST_IDLE && cmd_valid && ready_q) cksum_d = '0;
        else if (cs_q && we_q)                          cksum_d = cksum_q + wdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cksum_q <= '0;
        else          cksum_q <= cksum_d;
    end

    assign checksum = cksum_q;
`else
    assign checksum = '0;
`endif

    assign cmd_ready      = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = we_q;
    assign avm_byteenable = '1;
    assign avm_writedata  = wdata_q;
    assign avm_clken      = clken_q;

endmodule
